// File: rtl/sram_pkg.sv
// Shared sizing constants and word type for the serially loaded SRAM block.
package sram_pkg;

    localparam int SRAM_ROWS = 16;
    localparam int SRAM_COLS = 8;

    typedef logic [SRAM_COLS-1:0] word_t;

endpackage : sram_pkg

// File: rtl/sram_sipo.sv
// Serial-in parallel-out write-data loader. Shifting runs at half the clock
// rate: each serial bit is held for two clocks and captured on the second.
module sram_sipo
    import sram_pkg::*;
#(
    parameter int COLS = SRAM_COLS
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            serial_in,
    input  logic            shift,
    output logic [COLS-1:0] wdata
);

    logic phase_r;
    logic [COLS-1:0] wdata_r;

    // Phase toggle and MSB-first shift on every second clock while shift is held
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            phase_r <= 1'b0;
            wdata_r <= {COLS{1'b0}};
        end else if (shift) begin
            phase_r <= ~phase_r;
            if (phase_r) begin
                wdata_r <= {wdata_r[COLS-2:0], serial_in};
            end
        end else begin
            phase_r <= 1'b0;
        end
    end

    assign wdata = wdata_r;

endmodule : sram_sipo

// File: rtl/sram_top.sv
// Small SRAM with a serially loaded write-data register, one-cycle registered
// reads and read-before-write behaviour when both strobes coincide.
module sram_top
    import sram_pkg::*;
#(
    parameter int ROWS = SRAM_ROWS,
    parameter int COLS = SRAM_COLS
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    serial_in,
    input  logic                    shift,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [$clog2(ROWS)-1:0] addr,
    output logic                    data_valid,
    output logic [COLS-1:0]         data_out
);

    localparam int AW = $clog2(ROWS);

    logic [COLS-1:0] wdata_s;
    logic [COLS-1:0] mem_r [ROWS];
    logic [COLS-1:0] data_out_r;
    logic            data_valid_r;

    sram_sipo #(
        .COLS (COLS)
    ) u_sipo (
        .clk       (clk),
        .arst_n    (arst_n),
        .serial_in (serial_in),
        .shift     (shift),
        .wdata     (wdata_s)
    );

    // Storage array: cleared by reset, written from the pre-shift write-data word
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_r[i[AW-1:0]] <= {COLS{1'b0}};
            end
        end else if (w_en) begin
            mem_r[addr] <= wdata_s;
        end
    end

    // Registered read port; non-blocking read returns contents before a same-edge write
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_out_r   <= {COLS{1'b0}};
            data_valid_r <= 1'b0;
        end else if (r_en) begin
            data_out_r   <= mem_r[addr];
            data_valid_r <= 1'b1;
        end else begin
            data_valid_r <= 1'b0;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;

endmodule : sram_top

// File: tb/tb_sram_top.sv
// Scoreboard bench for sram_top: reads push expected words into a queue and a
// monitor pops and compares whenever data_valid is seen.
module tb_sram_top;
    import sram_pkg::*;

    localparam int ROWS = SRAM_ROWS;
    localparam int COLS = SRAM_COLS;
    localparam int AW   = $clog2(ROWS);

    logic            clk;
    logic            arst_n;
    logic            serial_in;
    logic            shift;
    logic            w_en;
    logic            r_en;
    logic [AW-1:0]   addr;
    logic            data_valid;
    logic [COLS-1:0] data_out;

    int checks = 0;
    int errors = 0;
    word_t exp_q[$];

    sram_top #(.ROWS(ROWS), .COLS(COLS)) u_dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .serial_in  (serial_in),
        .shift      (shift),
        .w_en       (w_en),
        .r_en       (r_en),
        .addr       (addr),
        .data_valid (data_valid),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare each presented read word against the scoreboard head
    always @(posedge clk) begin
        #1;
        if (arst_n && data_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: data_valid=1 data_out=%h with no read pending", data_out);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h", data_out, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic load_word(input word_t w);
        for (int i = COLS - 1; i >= 0; i--) begin
            @(negedge clk);
            shift = 1'b1;
            serial_in = w[i];
            @(negedge clk);
        end
        @(negedge clk);
        shift = 1'b0;
        serial_in = 1'b0;
    endtask

    task automatic write_row(input logic [AW-1:0] a);
        @(negedge clk);
        w_en = 1'b1;
        addr = a;
        @(negedge clk);
        w_en = 1'b0;
    endtask

    task automatic read_row(input logic [AW-1:0] a, input word_t e);
        @(negedge clk);
        r_en = 1'b1;
        addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        r_en = 1'b0;
        @(negedge clk);
        check("read_drained", exp_q.size(), 32'd0);
    endtask

    // Watchdog so a broken design can never hang the run
    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        word_t held;
        serial_in = 1'b0;
        shift = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        addr = {AW{1'b0}};
        arst_n = 1'b0;
        #20;
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_data_valid", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        read_row(4'd0, 8'h00);
        read_row(4'd5, 8'h00);
        read_row(4'd15, 8'h00);

        // All ones into row 1, then pulse-width check on data_valid
        load_word(8'hFF);
        write_row(4'd1);
        read_row(4'd1, 8'hFF);
        check("valid_low_after_pulse", {31'd0, data_valid}, 32'd0);

        // Pattern and MSB ordering
        load_word(8'hA5);
        write_row(4'd2);
        load_word(8'h3C);
        write_row(4'd3);
        read_row(4'd2, 8'hA5);
        read_row(4'd3, 8'h3C);
        read_row(4'd1, 8'hFF);

        // Simultaneous write and read: old contents returned
        load_word(8'h0F);
        @(negedge clk);
        w_en = 1'b1;
        r_en = 1'b1;
        addr = 4'd2;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        check("simul_drained", exp_q.size(), 32'd0);
        read_row(4'd2, 8'h0F);

        // Same word may be written to several rows; back-to-back reads honoured
        write_row(4'd7);
        @(negedge clk);
        r_en = 1'b1;
        addr = 4'd7;
        exp_q.push_back(8'h0F);
        @(negedge clk);
        addr = 4'd3;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        r_en = 1'b0;
        @(negedge clk);
        check("b2b_drained", exp_q.size(), 32'd0);

        // Idle hold: no valid and data_out frozen for 10 clocks
        held = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_valid", {31'd0, data_valid}, 32'd0);
            check("idle_hold", {24'd0, data_out}, {24'd0, held});
        end

        // Reset in the middle of a serial load
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            shift = 1'b1;
            serial_in = 1'b1;
            @(negedge clk);
        end
        #2;
        arst_n = 1'b0;
        #1;
        check("midload_wdata", {24'd0, u_dut.u_sipo.wdata}, 32'd0);
        check("midload_data_out", {24'd0, data_out}, 32'd0);
        shift = 1'b0;
        serial_in = 1'b0;
        #20;
        @(negedge clk);
        arst_n = 1'b1;
        read_row(4'd1, 8'h00);
        load_word(8'h5A);
        write_row(4'd4);
        read_row(4'd4, 8'h5A);

        repeat (3) @(negedge clk);
        check("final_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sram_top

// File: doc/sram_top.md
SRAM_TOP -- requirements
Module: sram_top

Interface
REQ-001 SHALL take parameter ROWS, default 16, word count; must be a power of two, at least 2.
REQ-002 SHALL take parameter COLS, default 8, word width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port serial_in, input, 1 bit: serial write-data bit, MSB first.
REQ-006 SHALL have port shift, input, 1 bit: enables serial loading of the write-data register.
REQ-007 SHALL have port w_en, input, 1 bit: write strobe.
REQ-008 SHALL have port r_en, input, 1 bit: read strobe.
REQ-009 SHALL have port addr, input, $clog2(ROWS) bits: row address for read and write.
REQ-010 SHALL have port data_valid, output, 1 bit: one-cycle pulse marking new data_out.
REQ-011 SHALL have port data_out, output, COLS bits: registered read data.

Function
REQ-012 SHALL hold a COLS-bit write-data shift register (wdata) and a ROWS x COLS storage array.
REQ-013 SHALL divide shifting by two with a phase bit: cleared while shift=0, toggles every clock while shift=1.
REQ-014 SHALL shift when shift=1 and phase=1: wdata <= {wdata[COLS-2:0], serial_in}. Each bit is presented for 2 clocks; shift held for 2*COLS clocks loads exactly one word, MSB first.
REQ-015 SHALL write on a clock with w_en=1: mem[addr] <= wdata, using the wdata value before any same-edge shift.
REQ-016 SHALL read on a clock with r_en=1: data_out <= mem[addr] and data_valid <= 1 on that same edge (1-cycle latency).
REQ-017 SHALL drive data_valid=0 on every clock with r_en=0; data_out holds its last value.
REQ-018 SHALL, when w_en and r_en are both high, perform both operations; read returns the pre-write contents (read-before-write).
REQ-019 SHALL sample addr on the same edge as the strobe; back-to-back strobes on consecutive cycles are each honoured.
REQ-020 SHALL leave wdata unchanged by writes; the same word may be written to several rows.

Reset
REQ-021 SHALL, while arst_n=0, immediately force wdata=0, phase=0, all mem rows=0, data_out=0, data_valid=0.
REQ-022 SHALL abort any partial serial load or pending strobe on reset; operation resumes on the first edge after arst_n rises.

Structure
REQ-023 SHALL take ROWS and COLS defaults from shared package sram_pkg, which the testbench also imports.
REQ-024 SHALL implement the serial loader (phase bit plus wdata) as sub-module sram_sipo, parameterised by COLS; the array and read/write control stay in sram_top.

Verification
REQ-025 SHALL check reset: arst_n=0 for 20 ns -> data_out=0, data_valid=0, and a read of any row after release returns 0.
REQ-026 SHALL check write/read of all ones: shift in all ones (2 clk/bit), w_en for 1 clk at addr=1, then r_en for 1 clk -> next edge data_out all ones, data_valid=1 for exactly 1 cycle.
REQ-027 SHALL check pattern and MSB order: with COLS=8, shift 8'hA5 into addr=2 and 8'h3C into addr=3, then read both -> 8'hA5 and 8'h3C; addr=1 still all ones.
REQ-028 SHALL check simultaneous access: w_en=r_en=1 at addr=2 with wdata=8'h0F -> data_out=8'hA5 this read; next read of addr=2 returns 8'h0F.
REQ-029 SHALL check reset mid-load: arst_n pulsed low after 4 bits shifted -> wdata=0; a full new word then loads correctly.
REQ-030 SHALL check idle hold: r_en=0 for 10 clocks -> data_valid=0 throughout and data_out unchanged.
